// File: rtl/ariane_pkg.sv
// Shared core constants and helpers used by the renamer and the commit-side tracker.
package ariane_pkg;

    localparam int unsigned NR_COMMIT_PORTS = 2;
    localparam int unsigned RENAME_NAME_W   = 6;

    // GPR x0 lives under both name-bit values (0x00 and 0x20) and never has a tracked writer.
    function automatic logic is_zero_name(input logic [RENAME_NAME_W-1:0] name, input logic fpr);
        return !fpr && ((name == 6'h00) || (name == 6'h20));
    endfunction

endpackage

// File: rtl/rename_cnt_cell.sv
// One in-flight writer counter: q + inc - dec, clamped to [0, 2^CNT_W-1], with flush.
module rename_cnt_cell #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned DEC_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             inc_i,
    input  logic [DEC_W-1:0] dec_i,
    output logic             is_max_o,
    output logic             is_zero_o,
    output logic             underflow_o
);

    localparam int unsigned SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 2;
    localparam logic [SUM_W-1:0] MAX_V = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_diff;
    logic [CNT_W-1:0] w_next;
    logic             w_uf;

    always_comb begin
        w_sum  = SUM_W'(r_cnt) + SUM_W'(inc_i);
        w_diff = w_sum - SUM_W'(dec_i);
        w_uf   = w_sum < SUM_W'(dec_i);
        w_next = w_diff[CNT_W-1:0];
        if (w_uf) begin
            w_next = '0;
        end else if (w_diff > MAX_V) begin
            w_next = '1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    // Flush discards the commit, so a flushed underflow is not reported.
    assign underflow_o = w_uf && !flush_i;
    assign is_max_o    = (r_cnt == '1);
    assign is_zero_o   = (r_cnt == '0);

endmodule

// File: rtl/rename_commit_tracker.sv
// Per-name in-flight writer tracking: issue increments, commit decrements, busy/stall lookup.
module rename_commit_tracker
    import ariane_pkg::*;
#(
    parameter int unsigned NR_COMMIT_PORTS = ariane_pkg::NR_COMMIT_PORTS,
    parameter int unsigned CNT_W           = 2
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          flush_i,
    input  logic                                          issue_valid_i,
    input  logic [RENAME_NAME_W-1:0]                      issue_rd_i,
    input  logic                                          issue_rd_fpr_i,
    output logic                                          issue_stall_o,
    input  logic [NR_COMMIT_PORTS-1:0]                    commit_valid_i,
    input  logic [NR_COMMIT_PORTS-1:0][RENAME_NAME_W-1:0] commit_rd_i,
    input  logic [NR_COMMIT_PORTS-1:0]                    commit_fpr_i,
    input  logic [2:0][RENAME_NAME_W-1:0]                 rs_name_i,
    input  logic [2:0]                                    rs_fpr_i,
    output logic [2:0]                                    rs_busy_o,
    output logic                                          underflow_o
);

    localparam int unsigned N_ENTRIES = 2 ** (RENAME_NAME_W + 1);
    localparam int unsigned DEC_W     = $clog2(NR_COMMIT_PORTS + 1);

    logic [N_ENTRIES-1:0] w_is_max;
    logic [N_ENTRIES-1:0] w_is_zero;
    logic [N_ENTRIES-1:0] w_uf;
    logic                 r_underflow;

    for (genvar e = 0; e < N_ENTRIES; e++) begin : g_entry
        localparam logic [RENAME_NAME_W:0] IDX = (RENAME_NAME_W + 1)'(e);
        if (is_zero_name(IDX[RENAME_NAME_W-1:0], IDX[RENAME_NAME_W])) begin : g_x0
            assign w_is_max[e]  = 1'b0;
            assign w_is_zero[e] = 1'b1;
            assign w_uf[e]      = 1'b0;
        end else begin : g_cnt
            logic             w_inc;
            logic [DEC_W-1:0] w_dec;

            always_comb begin
                w_inc = issue_valid_i && ({issue_rd_fpr_i, issue_rd_i} == IDX);
                w_dec = '0;
                for (int unsigned p = 0; p < NR_COMMIT_PORTS; p++) begin
                    if (commit_valid_i[p] && ({commit_fpr_i[p], commit_rd_i[p]} == IDX)) begin
                        w_dec = w_dec + DEC_W'(1);
                    end
                end
            end

            rename_cnt_cell #(
                .CNT_W (CNT_W),
                .DEC_W (DEC_W)
            ) u_cell (
                .clk_i       (clk_i),
                .rst_ni      (rst_ni),
                .flush_i     (flush_i),
                .inc_i       (w_inc),
                .dec_i       (w_dec),
                .is_max_o    (w_is_max[e]),
                .is_zero_o   (w_is_zero[e]),
                .underflow_o (w_uf[e])
            );
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= r_underflow | (|w_uf);
        end
    end

    always_comb begin
        issue_stall_o = w_is_max[{issue_rd_fpr_i, issue_rd_i}];
        for (int unsigned i = 0; i < 3; i++) begin
            rs_busy_o[i] = !w_is_zero[{rs_fpr_i[i], rs_name_i[i]}];
        end
    end

    assign underflow_o = r_underflow;

    a_no_issue_when_stalled : assert property (
        @(posedge clk_i) disable iff (!rst_ni || flush_i) !(issue_valid_i && issue_stall_o));

endmodule
